// File: rtl/biriscv_mul_track_pkg.sv
// Shared RV32M multiply decode definitions and helpers for the multiply tracker.
// Provides the MUL/MULH/MULHSU/MULHU match values, the funct7/funct3/opcode mask,
// and a decode helper used by the tracker top.
package biriscv_mul_track_pkg;

    typedef logic [4:0] rd_idx_t;

    localparam logic [31:0] INST_MUL_MASK = 32'hFE00707F;
    localparam logic [31:0] INST_MUL      = 32'h02000033;
    localparam logic [31:0] INST_MULH     = 32'h02001033;
    localparam logic [31:0] INST_MULHSU   = 32'h02002033;
    localparam logic [31:0] INST_MULHU    = 32'h02003033;

    // True when the instruction word is one of the four multiply variants.
    function automatic logic is_mul_inst(input logic [31:0] op);
        logic [31:0] masked;
        masked = op & INST_MUL_MASK;
        return (masked == INST_MUL)   || (masked == INST_MULH) ||
               (masked == INST_MULHSU) || (masked == INST_MULHU);
    endfunction

endpackage

// File: rtl/biriscv_mul_track_stage.sv
// One shadow-pipeline stage: a valid bit plus destination index.
// Ports: clk_i/rst_i (sync active-high), hold_i freezes the stage, kill_i drops
// the incoming op, valid_i/rd_i next-stage input, valid_o/rd_o registered state.
module biriscv_mul_track_stage
    import biriscv_mul_track_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    hold_i,
    input  logic    kill_i,
    input  logic    valid_i,
    input  rd_idx_t rd_i,
    output logic    valid_o,
    output rd_idx_t rd_o
);

    logic    valid_d, valid_q;
    rd_idx_t rd_d, rd_q;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        // Hold freezes the stage exactly like the multiplier's own registers,
        // which is also why a kill arriving during hold is ignored.
        if (!hold_i) begin
            valid_d = valid_i & ~kill_i;
            rd_d    = rd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // rd is always qualified by valid downstream, so it carries no reset.
    always_ff @(posedge clk_i) begin
        rd_q <= rd_d;
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;

endmodule

// File: rtl/biriscv_mul_track.sv
// Tracks in-flight multiplies alongside the multiplier pipeline: shadows valid/rd
// for stages e1..eMULT_STAGES, produces the writeback strobe/index, a busy-register
// bitmap and a RAW hazard flag for the issuing instruction.
// Ports: clk_i, rst_i (sync active-high), opcode_* issue slot, hold_i, flush_i,
// mul_result_i; outputs wb_valid_o/wb_rd_idx_o/wb_value_o, busy_rd_o, raw_hazard_o.
module biriscv_mul_track #(
    parameter int MULT_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [4:0]  opcode_ra_idx_i,
    input  logic [4:0]  opcode_rb_idx_i,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic [31:0] mul_result_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_value_o,
    output logic [31:0] busy_rd_o,
    output logic        raw_hazard_o
);
    import biriscv_mul_track_pkg::*;

    logic                        mul_inst;
    logic                        issue;
    logic [MULT_STAGES-1:0]      in_valid;
    logic [MULT_STAGES-1:0]      kill;
    logic [MULT_STAGES-1:0][4:0] in_rd;
    logic [MULT_STAGES-1:0]      stg_valid;
    logic [MULT_STAGES-1:0][4:0] stg_rd;
    logic [31:0]                 busy;

    assign mul_inst = is_mul_inst(opcode_opcode_i);
    assign issue    = opcode_valid_i & mul_inst & ~hold_i & ~flush_i & ~raw_hazard_o;

    // Stage inputs: e1 takes the issue slot, later stages take their predecessor.
    // Flush kills the youngest in-flight op (the one in e1) as it would move to
    // e2, and blocks the new issue into e1; older stages are untouched.
    always_comb begin
        in_valid    = '0;
        in_rd       = '0;
        kill        = '0;
        in_valid[0] = issue;
        in_rd[0]    = opcode_rd_idx_i;
        for (int i = 1; i < MULT_STAGES; i++) begin
            in_valid[i] = stg_valid[i-1];
            in_rd[i]    = stg_rd[i-1];
        end
        kill[0] = flush_i;
        kill[1] = flush_i;
    end

    for (genvar g = 0; g < MULT_STAGES; g++) begin : g_stage
        biriscv_mul_track_stage u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .hold_i  (hold_i),
            .kill_i  (kill[g]),
            .valid_i (in_valid[g]),
            .rd_i    (in_rd[g]),
            .valid_o (stg_valid[g]),
            .rd_o    (stg_rd[g])
        );
    end

    // The final stage is left out: the regfile bypass covers writeback there.
    // x0 is never marked busy.
    always_comb begin
        busy = '0;
        for (int i = 0; i < MULT_STAGES - 1; i++) begin
            if (stg_valid[i] && (stg_rd[i] != 5'd0)) begin
                busy[stg_rd[i]] = 1'b1;
            end
        end
    end

    assign busy_rd_o    = busy;
    assign raw_hazard_o = opcode_valid_i & (busy[opcode_ra_idx_i] | busy[opcode_rb_idx_i]);

    assign wb_valid_o  = stg_valid[MULT_STAGES-1] & ~hold_i;
    assign wb_rd_idx_o = stg_rd[MULT_STAGES-1];
    assign wb_value_o  = mul_result_i;

endmodule

// File: tb/tb_biriscv_mul_track.sv
// Directed bench for the multiply tracker: one instance at two stages and one at three,
// both driven by the same stimulus; each step checks against hand-computed values.
module tb_biriscv_mul_track;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        opcode_valid_i;
    logic [31:0] opcode_opcode_i;
    logic [4:0]  opcode_rd_idx_i;
    logic [4:0]  opcode_ra_idx_i;
    logic [4:0]  opcode_rb_idx_i;
    logic        hold_i;
    logic        flush_i;
    logic [31:0] mul_result_i;

    logic        a_wb_valid, b_wb_valid;
    logic [4:0]  a_wb_rd, b_wb_rd;
    logic [31:0] a_wb_value, b_wb_value;
    logic [31:0] a_busy, b_busy;
    logic        a_haz, b_haz;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    biriscv_mul_track #(.MULT_STAGES(2)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_valid_i(opcode_valid_i),
        .opcode_opcode_i(opcode_opcode_i), .opcode_rd_idx_i(opcode_rd_idx_i),
        .opcode_ra_idx_i(opcode_ra_idx_i), .opcode_rb_idx_i(opcode_rb_idx_i),
        .hold_i(hold_i), .flush_i(flush_i), .mul_result_i(mul_result_i),
        .wb_valid_o(a_wb_valid), .wb_rd_idx_o(a_wb_rd), .wb_value_o(a_wb_value),
        .busy_rd_o(a_busy), .raw_hazard_o(a_haz)
    );

    biriscv_mul_track #(.MULT_STAGES(3)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_valid_i(opcode_valid_i),
        .opcode_opcode_i(opcode_opcode_i), .opcode_rd_idx_i(opcode_rd_idx_i),
        .opcode_ra_idx_i(opcode_ra_idx_i), .opcode_rb_idx_i(opcode_rb_idx_i),
        .hold_i(hold_i), .flush_i(flush_i), .mul_result_i(mul_result_i),
        .wb_valid_o(b_wb_valid), .wb_rd_idx_o(b_wb_rd), .wb_value_o(b_wb_value),
        .busy_rd_o(b_busy), .raw_hazard_o(b_haz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] op, input logic [4:0] rd,
                         input logic [4:0] ra, input logic [4:0] rb);
        opcode_valid_i  = v;
        opcode_opcode_i = op;
        opcode_rd_idx_i = rd;
        opcode_ra_idx_i = ra;
        opcode_rb_idx_i = rb;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0000_0013, 5'd0, 5'd0, 5'd0);
    endtask

    localparam logic [31:0] OP_MUL   = 32'h0220_8033;
    localparam logic [31:0] OP_MULH  = 32'h0220_9033;
    localparam logic [31:0] OP_MULHU = 32'h0220_B033;
    localparam logic [31:0] OP_ADD   = 32'h0020_8033;

    initial begin
        rst_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0; mul_result_i = 32'h0;
        idle();
        tick(); tick();
        rst_i = 1'b0;

        // Reset state
        chk("rst_wb_valid2", {31'd0, a_wb_valid}, 32'd0);
        chk("rst_busy2", a_busy, 32'd0);
        chk("rst_wb_valid3", {31'd0, b_wb_valid}, 32'd0);
        chk("rst_busy3", b_busy, 32'd0);
        drive(1'b1, OP_ADD, 5'd3, 5'd5, 5'd0);
        chk("rst_haz", {31'd0, a_haz}, 32'd0);

        // Single MUL rd=5
        mul_result_i = 32'h1234_5678;
        drive(1'b1, OP_MUL, 5'd5, 5'd1, 5'd2);
        chk("s1_issue_haz", {31'd0, a_haz}, 32'd0);
        tick(); idle();
        chk("s1_e1_busy2", a_busy, 32'h0000_0020);
        chk("s1_e1_wb2", {31'd0, a_wb_valid}, 32'd0);
        tick();
        chk("s1_wb_valid2", {31'd0, a_wb_valid}, 32'd1);
        chk("s1_wb_rd2", {27'd0, a_wb_rd}, 32'd5);
        chk("s1_wb_value2", a_wb_value, 32'h1234_5678);
        chk("s1_wb_busy2", a_busy, 32'd0);
        chk("s1_e2_busy3", b_busy, 32'h0000_0020);
        chk("s1_e2_wb3", {31'd0, b_wb_valid}, 32'd0);
        tick();
        chk("s1_after_wb2", {31'd0, a_wb_valid}, 32'd0);
        chk("s1_wb_valid3", {31'd0, b_wb_valid}, 32'd1);
        chk("s1_wb_rd3", {27'd0, b_wb_rd}, 32'd5);
        tick();
        chk("s1_after_wb3", {31'd0, b_wb_valid}, 32'd0);

        // MUL rd=7 followed by ADD reading x7
        drive(1'b1, OP_MUL, 5'd7, 5'd3, 5'd4);
        tick();
        mul_result_i = 32'hCAFE_F00D;
        drive(1'b1, OP_ADD, 5'd9, 5'd7, 5'd1);
        chk("s2_haz_on2", {31'd0, a_haz}, 32'd1);
        chk("s2_haz_on3", {31'd0, b_haz}, 32'd1);
        tick();
        chk("s2_haz_off2", {31'd0, a_haz}, 32'd0);
        chk("s2_wb_valid2", {31'd0, a_wb_valid}, 32'd1);
        chk("s2_wb_rd2", {27'd0, a_wb_rd}, 32'd7);
        chk("s2_wb_value2", a_wb_value, 32'hCAFE_F00D);
        idle();
        tick(); tick();
        chk("s2_drained3", {31'd0, b_wb_valid}, 32'd0);

        // MULH rd=9, hold for three edges while it sits in the final stage
        drive(1'b1, OP_MULH, 5'd9, 5'd1, 5'd2);
        tick(); idle();
        tick();
        chk("s3_wb_pre_hold2", {31'd0, a_wb_valid}, 32'd1);
        hold_i = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("s3_hold_wb2", {31'd0, a_wb_valid}, 32'd0);
            chk("s3_hold_rd2", {27'd0, a_wb_rd}, 32'd9);
            chk("s3_hold_busy3", b_busy, 32'h0000_0200);
            chk("s3_hold_wb3", {31'd0, b_wb_valid}, 32'd0);
            tick();
        end
        hold_i = 1'b0; #1;
        chk("s3_release_wb2", {31'd0, a_wb_valid}, 32'd1);
        chk("s3_release_rd2", {27'd0, a_wb_rd}, 32'd9);
        tick();
        chk("s3_done2", {31'd0, a_wb_valid}, 32'd0);
        chk("s3_wb_valid3", {31'd0, b_wb_valid}, 32'd1);
        chk("s3_wb_rd3", {27'd0, b_wb_rd}, 32'd9);
        tick();

        // MULHU rd=11 flushed while in e1
        drive(1'b1, OP_MULHU, 5'd11, 5'd1, 5'd2);
        tick(); idle();
        flush_i = 1'b1; #1;
        chk("s4_pre_flush_busy3", b_busy, 32'h0000_0800);
        tick();
        flush_i = 1'b0; #1;
        chk("s4_flushed_busy3", b_busy, 32'd0);
        chk("s4_flushed_wb2", {31'd0, a_wb_valid}, 32'd0);
        tick();
        chk("s4_flushed_wb3a", {31'd0, b_wb_valid}, 32'd0);
        tick();
        chk("s4_flushed_wb3b", {31'd0, b_wb_valid}, 32'd0);

        // Flush blocks an issue presented in the same cycle
        flush_i = 1'b1;
        drive(1'b1, OP_MUL, 5'd12, 5'd1, 5'd2);
        tick();
        flush_i = 1'b0; idle();
        chk("s4b_blocked_busy2", a_busy, 32'd0);

        // Four back-to-back MULs rd=1..4
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, OP_MUL, 5'(i), 5'd10, 5'd12);
            chk("s5_no_haz", {31'd0, a_haz}, 32'd0);
            tick();
            chk("s5_busy2", a_busy, 32'd1 << i);
            if (i >= 2) begin
                chk("s5_wb_valid2", {31'd0, a_wb_valid}, 32'd1);
                chk("s5_wb_rd2", {27'd0, a_wb_rd}, 32'(i - 1));
            end
        end
        idle();
        tick();
        chk("s5_wb_valid_last2", {31'd0, a_wb_valid}, 32'd1);
        chk("s5_wb_rd_last2", {27'd0, a_wb_rd}, 32'd4);
        chk("s5_wb_rd_last3", {27'd0, b_wb_rd}, 32'd3);
        tick();
        chk("s5_end2", {31'd0, a_wb_valid}, 32'd0);
        tick();

        // MUL with rd=0 is tracked but never busy
        drive(1'b1, OP_MUL, 5'd0, 5'd1, 5'd2);
        tick(); idle();
        chk("s6_rd0_busy2", a_busy, 32'd0);
        tick();
        chk("s6_rd0_wb2", {31'd0, a_wb_valid}, 32'd1);
        chk("s6_rd0_rd2", {27'd0, a_wb_rd}, 32'd0);
        tick();

        // Reset with two ops in flight
        drive(1'b1, OP_MUL, 5'd6, 5'd1, 5'd2);
        tick();
        drive(1'b1, OP_MUL, 5'd8, 5'd1, 5'd2);
        tick();
        chk("s7_pre_rst_busy3", b_busy, 32'h0000_0140);
        rst_i = 1'b1; hold_i = 1'b1; idle();
        tick();
        rst_i = 1'b0; hold_i = 1'b0; #1;
        chk("s7_rst_wb2", {31'd0, a_wb_valid}, 32'd0);
        chk("s7_rst_busy2", a_busy, 32'd0);
        chk("s7_rst_wb3", {31'd0, b_wb_valid}, 32'd0);
        chk("s7_rst_busy3", b_busy, 32'd0);
        tick();
        chk("s7_rst_wb3b", {31'd0, b_wb_valid}, 32'd0);

        // ADD never enters the tracker
        drive(1'b1, OP_ADD, 5'd13, 5'd1, 5'd2);
        tick(); idle();
        chk("s8_add_busy2", a_busy, 32'd0);
        chk("s8_add_busy3", b_busy, 32'd0);
        tick();
        chk("s8_add_wb2", {31'd0, a_wb_valid}, 32'd0);
        tick();
        chk("s8_add_wb3", {31'd0, b_wb_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
